// File: rtl/mrx_ctrl_hop_rx.sv
`default_nettype none
//============================================================================
// Module   : mrx_ctrl_hop_rx
// Desc     : Frequency-hopping RX controller (NCO phase, settle, symbol sums).
//            MRX_GPIO_SYNC_EN: hold IDLE until the first frame-sync edge.
// Revision : 1.0
//============================================================================
module mrx_ctrl_hop_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 24,
    parameter int NSIG        = 8192,
    parameter int NSYMB       = 16,
    parameter int NUM_HOPS    = 4,
    parameter int BASE_PH_INC = 4096,
    parameter int HOP_PH_STEP = 8192,
    parameter int NSETTLE     = 64,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic signed [DATA_WIDTH-1:0]  irx,
    input  logic signed [DATA_WIDTH-1:0]  qrx,
    input  logic                          rx_valid,
    input  logic [11:0]                   fp_gpio_in,
    output logic [11:0]                   fp_gpio_out,
    output logic [11:0]                   fp_gpio_ddr,
    output logic [PHASE_WIDTH-1:0]        rx_ph,
    output logic [PHASE_WIDTH-1:0]        hop_ph_inc,
    output logic [7:0]                    nhop,
    output logic [15:0]                   symbN,
    output logic [PHASE_WIDTH-1:0]        sigN,
    output logic signed [ACC_WIDTH-1:0]   sym_i,
    output logic signed [ACC_WIDTH-1:0]   sym_q,
    output logic                          sym_valid,
    input  logic                          sym_ready,
    output logic                          hop_done,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [1:0]                    rx_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_INTEG  = 2'd2
    } state_t;

    localparam int c_SETTLE_W = (NSETTLE > 1) ? $clog2(NSETTLE) : 1;

    state_t                        r_state;
    logic [PHASE_WIDTH-1:0]        r_rx_ph;
    logic [7:0]                    r_nhop;
    logic [15:0]                   r_symb;
    logic [PHASE_WIDTH-1:0]        r_sig;
    logic [c_SETTLE_W-1:0]         r_settle;
    logic signed [ACC_WIDTH-1:0]   r_acc_i;
    logic signed [ACC_WIDTH-1:0]   r_acc_q;
    logic signed [ACC_WIDTH-1:0]   r_sym_i;
    logic signed [ACC_WIDTH-1:0]   r_sym_q;
    logic                          r_sym_valid;
    logic                          r_hop_done;
    logic                          r_frame_done;
    logic                          r_overflow;

    logic                          w_sync_rise;
    logic                          w_auto_start;
    logic                          w_unused_gpio;
    logic [PHASE_WIDTH-1:0]        w_hop_ph_inc;
    logic signed [ACC_WIDTH-1:0]   w_i_ext;
    logic signed [ACC_WIDTH-1:0]   w_q_ext;
    logic signed [ACC_WIDTH-1:0]   w_sum_i;
    logic signed [ACC_WIDTH-1:0]   w_sum_q;
    logic                          w_last_sig;
    logic                          w_last_symb;
    logic                          w_last_hop;
    logic                          w_settle_done;
    logic                          w_new_result;

`ifdef MRX_GPIO_SYNC_EN
    // Two flops for metastability, third flop for rising-edge detection
    logic [2:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], fp_gpio_in[0]};
        end
    end

    assign w_sync_rise  = r_sync[1] & ~r_sync[2];
    assign w_auto_start = 1'b0;
`else
    assign w_sync_rise  = 1'b0;
    assign w_auto_start = 1'b1;
`endif

    assign w_unused_gpio = ^fp_gpio_in;

    assign w_hop_ph_inc = PHASE_WIDTH'(BASE_PH_INC)
                        + PHASE_WIDTH'(r_nhop) * PHASE_WIDTH'(HOP_PH_STEP);

    assign w_i_ext = ACC_WIDTH'(irx);
    assign w_q_ext = ACC_WIDTH'(qrx);
    assign w_sum_i = r_acc_i + w_i_ext;
    assign w_sum_q = r_acc_q + w_q_ext;

    assign w_last_sig    = (r_sig == PHASE_WIDTH'(NSIG - 1));
    assign w_last_symb   = (r_symb == 16'(NSYMB - 1));
    assign w_last_hop    = (r_nhop == 8'(NUM_HOPS - 1));
    assign w_settle_done = (r_settle == c_SETTLE_W'(NSETTLE - 1));
    assign w_new_result  = (r_state == ST_INTEG) && rx_valid && w_last_sig && !w_sync_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_rx_ph      <= '0;
            r_nhop       <= '0;
            r_symb       <= '0;
            r_sig        <= '0;
            r_settle     <= '0;
            r_acc_i      <= '0;
            r_acc_q      <= '0;
            r_sym_i      <= '0;
            r_sym_q      <= '0;
            r_sym_valid  <= 1'b0;
            r_hop_done   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_hop_done   <= 1'b0;
            r_frame_done <= 1'b0;

            // A fresh result always wins; an unaccepted one it replaces is lost
            if (w_new_result) begin
                r_sym_i     <= w_sum_i;
                r_sym_q     <= w_sum_q;
                r_sym_valid <= 1'b1;
                if (r_sym_valid && !sym_ready) begin
                    r_overflow <= 1'b1;
                end
            end else if (r_sym_valid && sym_ready) begin
                r_sym_valid <= 1'b0;
            end

            if (w_sync_rise) begin
                r_state  <= ST_SETTLE;
                r_nhop   <= '0;
                r_symb   <= '0;
                r_sig    <= '0;
                r_settle <= '0;
                r_rx_ph  <= '0;
                r_acc_i  <= '0;
                r_acc_q  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_auto_start) begin
                            r_state  <= ST_SETTLE;
                            r_settle <= '0;
                        end
                    end
                    ST_SETTLE: begin
                        if (rx_valid) begin
                            r_rx_ph <= r_rx_ph + w_hop_ph_inc;
                            if (w_settle_done) begin
                                r_state  <= ST_INTEG;
                                r_settle <= '0;
                                r_sig    <= '0;
                                r_acc_i  <= '0;
                                r_acc_q  <= '0;
                            end else begin
                                r_settle <= r_settle + c_SETTLE_W'(1);
                            end
                        end
                    end
                    ST_INTEG: begin
                        if (rx_valid) begin
                            if (w_last_sig) begin
                                r_sig   <= '0;
                                r_acc_i <= '0;
                                r_acc_q <= '0;
                                if (w_last_symb) begin
                                    // Hop boundary: retune and settle again
                                    r_symb     <= '0;
                                    r_rx_ph    <= '0;
                                    r_hop_done <= 1'b1;
                                    r_state    <= ST_SETTLE;
                                    r_settle   <= '0;
                                    if (w_last_hop) begin
                                        r_nhop       <= '0;
                                        r_frame_done <= 1'b1;
                                    end else begin
                                        r_nhop <= r_nhop + 8'd1;
                                    end
                                end else begin
                                    r_symb  <= r_symb + 16'd1;
                                    r_rx_ph <= r_rx_ph + w_hop_ph_inc;
                                end
                            end else begin
                                r_sig   <= r_sig + PHASE_WIDTH'(1);
                                r_acc_i <= w_sum_i;
                                r_acc_q <= w_sum_q;
                                r_rx_ph <= r_rx_ph + w_hop_ph_inc;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rx_state    = r_state;
    assign rx_ph       = r_rx_ph;
    assign hop_ph_inc  = w_hop_ph_inc;
    assign nhop        = r_nhop;
    assign symbN       = r_symb;
    assign sigN        = r_sig;
    assign sym_i       = r_sym_i;
    assign sym_q       = r_sym_q;
    assign sym_valid   = r_sym_valid;
    assign hop_done    = r_hop_done;
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;
    assign fp_gpio_ddr = 12'h000;
    assign fp_gpio_out = {9'b0, r_overflow, r_sym_valid, (r_state != ST_IDLE)};

endmodule
`default_nettype wire

// File: tb/tb_mrx_ctrl_hop_rx.sv
`default_nettype none
//============================================================================
// Module   : tb_mrx_ctrl_hop_rx
// Desc     : Directed self-checking bench for mrx_ctrl_hop_rx (free-run build).
// Revision : 1.0
//============================================================================
module tb_mrx_ctrl_hop_rx;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic signed [15:0] irx = '0;
    logic signed [15:0] qrx = '0;
    logic               rx_valid = 1'b0;
    logic [11:0]        fp_gpio_in = '0;
    logic [11:0]        fp_gpio_out;
    logic [11:0]        fp_gpio_ddr;
    logic [23:0]        rx_ph;
    logic [23:0]        hop_ph_inc;
    logic [7:0]         nhop;
    logic [15:0]        symbN;
    logic [23:0]        sigN;
    logic signed [31:0] sym_i;
    logic signed [31:0] sym_q;
    logic               sym_valid;
    logic               sym_ready = 1'b0;
    logic               hop_done;
    logic               frame_done;
    logic               overflow;
    logic [1:0]         rx_state;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mrx_ctrl_hop_rx #(
        .DATA_WIDTH (16),
        .PHASE_WIDTH(24),
        .NSIG       (4),
        .NSYMB      (2),
        .NUM_HOPS   (3),
        .BASE_PH_INC(16),
        .HOP_PH_STEP(8),
        .NSETTLE    (2),
        .ACC_WIDTH  (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irx        (irx),
        .qrx        (qrx),
        .rx_valid   (rx_valid),
        .fp_gpio_in (fp_gpio_in),
        .fp_gpio_out(fp_gpio_out),
        .fp_gpio_ddr(fp_gpio_ddr),
        .rx_ph      (rx_ph),
        .hop_ph_inc (hop_ph_inc),
        .nhop       (nhop),
        .symbN      (symbN),
        .sigN       (sigN),
        .sym_i      (sym_i),
        .sym_q      (sym_q),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .hop_done   (hop_done),
        .frame_done (frame_done),
        .overflow   (overflow),
        .rx_state   (rx_state)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic v, input int n);
        for (int k = 0; k < n; k++) begin
            rx_valid = v;
            tick();
        end
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1;
        check("rst_state",   rx_state, 0);
        check("rst_valid",   sym_valid, 0);
        check("rst_ph",      rx_ph, 0);
        check("rst_nhop",    nhop, 0);
        check("rst_inc",     hop_ph_inc, 16);
        check("rst_gpio",    fp_gpio_out, 0);
        check("rst_ddr",     fp_gpio_ddr, 0);
        check("rst_ovf",     overflow, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("start_settle", rx_state, 1);

        // Hop 0: two discarded samples, then symbols of 4 samples
        irx = 16'sd1;
        qrx = -16'sd2;
        samp(1'b1, 5);
        check("sym1_early", sym_valid, 0);
        samp(1'b1, 1);
        check("sym1_valid", sym_valid, 1);
        check("sym1_i",     sym_i, 4);
        check("sym1_q",     sym_q, -8);
        check("sym1_state", rx_state, 2);
        check("sym1_symbN", symbN, 1);
        check("sym1_ph",    rx_ph, 96);
        check("sym1_gpio",  fp_gpio_out, 3);
        check("sym1_ovf",   overflow, 0);

        // Second result while the first is still unaccepted
        samp(1'b1, 4);
        check("ovf_flag",   overflow, 1);
        check("ovf_i",      sym_i, 4);
        check("ovf_gpio2",  fp_gpio_out[2], 1);
        check("hop0_done",  hop_done, 1);
        check("hop0_frame", frame_done, 0);
        check("hop0_nhop",  nhop, 1);
        check("hop0_inc",   hop_ph_inc, 24);
        check("hop0_state", rx_state, 1);
        check("hop0_ph",    rx_ph, 0);
        check("hop0_symbN", symbN, 0);

        sym_ready = 1'b1;
        samp(1'b1, 1);
        check("accept_clr", sym_valid, 0);
        check("hd_pulse",   hop_done, 0);
        samp(1'b1, 8);
        check("hop1_early", hop_done, 0);
        samp(1'b1, 1);
        check("hop1_done",  hop_done, 1);
        check("hop1_frame", frame_done, 0);
        check("hop1_nhop",  nhop, 2);
        check("hop1_inc",   hop_ph_inc, 32);
        samp(1'b1, 9);
        check("hop2_early", frame_done, 0);
        samp(1'b1, 1);
        check("hop2_done",  hop_done, 1);
        check("frame_done", frame_done, 1);
        check("wrap_nhop",  nhop, 0);
        check("wrap_inc",   hop_ph_inc, 16);
        check("sym6_i",     sym_i, 4);

        // Sparse rx_valid: only valid cycles advance phase and index
        samp(1'b0, 1);
        check("fd_pulse",   frame_done, 0);
        check("gap_ph0",    rx_ph, 0);
        samp(1'b1, 1);
        check("tog_ph16",   rx_ph, 16);
        samp(1'b0, 1);
        check("tog_hold16", rx_ph, 16);
        samp(1'b1, 1);
        check("tog_ph32",   rx_ph, 32);
        check("tog_integ",  rx_state, 2);
        check("tog_sig0",   sigN, 0);
        samp(1'b0, 1);
        samp(1'b1, 1);
        check("tog_ph48",   rx_ph, 48);
        check("tog_sig1",   sigN, 1);
        samp(1'b0, 1);
        check("tog_sighold", sigN, 1);
        samp(1'b1, 1);
        check("pre_rst_sig", sigN, 2);

        // Reset in the middle of a symbol
        rx_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_state", rx_state, 0);
        check("mid_rst_sig",   sigN, 0);
        check("mid_rst_ph",    rx_ph, 0);
        check("mid_rst_valid", sym_valid, 0);
        check("mid_rst_i",     sym_i, 0);
        check("mid_rst_gpio",  fp_gpio_out, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("re_settle",  rx_state, 1);
        irx = 16'sd3;
        qrx = 16'sd5;
        samp(1'b1, 5);
        check("re_early",   sym_valid, 0);
        samp(1'b1, 1);
        check("re_valid",   sym_valid, 1);
        check("re_i",       sym_i, 12);
        check("re_q",       sym_q, 20);

        // New result arriving on the same cycle the old one is accepted
        sym_ready = 1'b0;
        irx = -16'sd1;
        qrx = 16'sd7;
        samp(1'b1, 3);
        check("hold_valid", sym_valid, 1);
        check("hold_i",     sym_i, 12);
        sym_ready = 1'b1;
        samp(1'b1, 1);
        check("same_valid", sym_valid, 1);
        check("same_i",     sym_i, -4);
        check("same_q",     sym_q, 28);
        check("same_ovf",   overflow, 0);
        check("same_hop",   hop_done, 1);
        check("same_nhop",  nhop, 1);
        samp(1'b0, 1);
        check("final_clr",  sym_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mrx_ctrl_hop_rx.md
MRX_CTRL_HOP_RX -- requirements
Module: mrx_ctrl_hop_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed width of input I/Q samples.
REQ-002 SHALL have parameter PHASE_WIDTH, default 24, width of the NCO phase output.
REQ-003 SHALL have parameter NSIG, default 8192, samples integrated per symbol (power of two, >=2).
REQ-004 SHALL have parameter NSYMB, default 16, symbols per hop.
REQ-005 SHALL have parameter NUM_HOPS, default 4, hops per frame.
REQ-006 SHALL have parameters BASE_PH_INC, default 4096, and HOP_PH_STEP, default 8192, NCO increments.
REQ-007 SHALL have parameter NSETTLE, default 64, samples discarded after each hop change.
REQ-008 SHALL have parameter ACC_WIDTH, default 32, width of result outputs.
REQ-009 clk  in  1  sole clock; reset_n  in  1  asynchronous, active-low reset.
REQ-010 irx, qrx  in  DATA_WIDTH each  signed downconverted samples; rx_valid  in  1  sample strobe.
REQ-011 fp_gpio_in  in  12  bit 0 = frame sync from transmitter; fp_gpio_out, fp_gpio_ddr  out  12  status/direction.
REQ-012 rx_ph  out  PHASE_WIDTH  NCO phase for external mixer; hop_ph_inc  out  PHASE_WIDTH  current increment.
REQ-013 nhop  out  8  hop index; symbN  out  16  symbol index in hop; sigN  out  PHASE_WIDTH  sample index in symbol.
REQ-014 sym_i, sym_q  out  ACC_WIDTH  signed symbol sums; sym_valid  out  1; sym_ready  in  1.
REQ-015 hop_done, frame_done, overflow  out  1 each; rx_state  out  2.

Function
REQ-016 SHALL implement states IDLE=0, SETTLE=1, INTEG=2 on rx_state.
REQ-017 SHALL advance sigN, accumulators and rx_ph only on cycles with rx_valid=1.
REQ-018 hop_ph_inc SHALL equal (BASE_PH_INC + nhop*HOP_PH_STEP) mod 2^PHASE_WIDTH; rx_ph SHALL add hop_ph_inc per valid sample, wrapping modulo 2^PHASE_WIDTH.
REQ-019 SETTLE SHALL discard NSETTLE valid samples, then enter INTEG with sigN=0 and accumulators 0.
REQ-020 INTEG SHALL sign-extend and add irx/qrx into accumulators; on the NSIG-th sample, the cycle after, sym_i/sym_q SHALL hold the full sum including that sample, sym_valid SHALL be 1, and accumulators restart at 0 with no sample gap.
REQ-021 sym_valid SHALL clear the cycle after sym_valid&sym_ready; a new result while sym_valid=1 and not accepted SHALL overwrite and set overflow (sticky).
REQ-022 A new result and acceptance in the same cycle SHALL keep sym_valid=1 with the new data, no overflow.
REQ-023 After NSYMB symbols: nhop increments (NUM_HOPS-1 wraps to 0), hop_done pulses 1 cycle, rx_ph resets to 0, symbN to 0, state SETTLE.
REQ-024 frame_done SHALL pulse 1 cycle together with hop_done on the wrap from NUM_HOPS-1 to 0.
REQ-025 fp_gpio_in[0] SHALL pass a 2-flop synchronizer; a synchronized rising edge SHALL, from any state, force nhop=0, symbN=0, sigN=0, rx_ph=0, accumulators 0, state SETTLE; a pending sym_valid is unaffected.
REQ-026 fp_gpio_ddr SHALL be 12'h000; fp_gpio_out SHALL be {9'b0, overflow, sym_valid, rx_state!=IDLE}.

Reset
REQ-027 On reset_n=0 all outputs and state SHALL clear to 0 (rx_state=IDLE, overflow=0, sym_valid=0, rx_ph=0, nhop=0) immediately; hop_ph_inc shall show BASE_PH_INC.
REQ-028 Reset mid-INTEG SHALL discard the partial symbol; no sym_valid results from it.

Configuration
REQ-029 Macro MRX_GPIO_SYNC_EN: defined -> block stays IDLE after reset until first sync edge (REQ-025).
REQ-030 Without MRX_GPIO_SYNC_EN: block enters SETTLE the first cycle after reset release, fp_gpio_in ignored, free-runs.

Verification (NSIG=4, NSYMB=2, NUM_HOPS=3, NSETTLE=2, BASE_PH_INC=16, HOP_PH_STEP=8)
REQ-031 Sync edge, then continuous rx_valid with irx=1, qrx=-2 -> 2 discarded, first sym_i=4, sym_q=-8, sym_valid exactly after 6th sample.
REQ-032 sym_ready held 0 over two symbols -> overflow=1, sym_i=4 (second result), fp_gpio_out[2]=1.
REQ-033 Run 6 symbols -> hop_done after symbols 2,4,6; hop_ph_inc 16,24,32,16; frame_done only after symbol 6; nhop returns 0.
REQ-034 rx_valid toggled every other cycle -> sigN/rx_ph advance only on valid cycles; rx_ph=48 after 3 valid hop-0 samples.
REQ-035 reset_n=0 mid-INTEG with sigN=2 -> all outputs 0 at once; next symbol sums only post-resync samples.
REQ-036 Build without MRX_GPIO_SYNC_EN, fp_gpio_in held 0 -> rx_state=SETTLE one cycle after reset release, first result after 6 samples.
